mandel_depth_engine: RTL and testbench
======================================

// Module: mandel_depth_engine
// PURPOSE
// - Iterative fixed-point Mandelbrot engine. It is the producer of the depth/max_iterations pair that the colour LUT stage consumes.
// - Accepts one point c = c_re + j*c_im and iterates z <= z^2 + c from z = 0, one iteration per clock.
// - Returns the escape depth, 10 bits wide, plus the max_iterations value it was run with.
// - Sits between the pixel coordinate generator (upstream) and the depth->colour stage (downstream).
// PARAMETERS
// - DATA_WIDTH   32  c_re/c_im width; signed fixed point with FRAC_BITS fraction bits
// - FRAC_BITS    28  fraction bits; 1.0 = 1<<FRAC_BITS
// - DEPTH_WIDTH  10  width of depth and max_iterations
// PORTS
// - clk                 in   1            single clock, rising edge
// - reset               in   1            asynchronous, active-high
// - in_valid            in   1            c_re/c_im/max_iterations are valid
// - in_ready            out  1            engine can accept a point
// - c_re, c_im          in   DATA_WIDTH   signed point; legal range [-4.0, 4.0)
// - max_iterations      in   DEPTH_WIDTH  iteration limit for this point
// - out_valid           out  1            depth result is valid
// - out_ready           in   1            downstream accepts the result
// - depth               out  DEPTH_WIDTH  escape iteration, or max_iterations if the point never escaped
// - out_max_iterations  out  DEPTH_WIDTH  copy of the max_iterations captured with this point
// BEHAVIOUR
// - Reset values:
//   - FSM = IDLE; out_valid = 0; depth = 0; out_max_iterations = 0; z = 0.
//   - in_ready = 0 while reset is high.
// - States:
//   - IDLE: in_ready = 1 only here. Handshake (in_valid & in_ready) latches c, max_iterations, z = 0, n = 0, then goes to ITER.
//   - ITER: one step per cycle on z_n, where n is the current count.
//     - If zr^2 + zi^2 > 4.0 (strict): depth = n, go to DONE.
//     - Else if n == max_iterations: depth = max_iterations, go to DONE.
//     - Else: z <= z^2 + c, n <= n + 1, stay in ITER.
//   - DONE: out_valid = 1. depth and out_max_iterations are held stable until out_ready is sampled high, then go to IDLE.
// - Latency: a point escaping at depth d asserts out_valid d+1 cycles after the accept edge. max_iterations = 0 gives depth 0 after 1 cycle.
// - Arithmetic:
//   - z is held at DATA_WIDTH+2 bits, so no wrap for |c| < 4 with |z_n| <= 2.
//   - Products are full width, then shifted right by FRAC_BITS using arithmetic shift (truncate toward -inf).
//   - zr^2 + zi^2 is compared at full product width against 4.0.
//   - z_{n+1} = (zr^2 - zi^2 + c_re, 2*zr*zi + c_im).
// - Boundaries:
//   - |z|^2 == 4.0 exactly does not escape.
//   - The comparison n == max_iterations uses the captured value, so input changes after accept are ignored.
//   - in_valid is ignored while in ITER or DONE; there is no overlap between points.
//   - out_ready high while out_valid is low has no effect.
//   - The engine does not return to IDLE and accept a new point in the same cycle as the out_ready handshake.
//   - Reset mid-ITER or mid-DONE aborts the point. No partial result is emitted.
// CONFIGURATION
// - Macro CARDIOID_CHECK_EN.
// - Defined: an extra CHECK state runs between IDLE and ITER and lasts exactly 2 cycles (pipelined multiplies).
//   - With x = c_re - 0.25 and q = x^2 + c_im^2, the point is "inside" if q*(q + x) <= c_im^2/4 (main cardioid) or (c_re + 1)^2 + c_im^2 <= 1/16 (period-2 bulb).
//   - If inside: depth = max_iterations and the FSM goes to DONE, so out_valid rises 2 cycles after accept.
//   - Otherwise: go to ITER with n = 0; depth values are identical to the undefined build.
// - Undefined: there is no CHECK state and IDLE goes directly to ITER.
// TESTING
// - c=(3.0,0), max=100 -> depth=1, out_max_iterations=100, out_valid 2 cycles after accept.
// - c=(1.0,0), max=100 -> z=1,2,5; depth=3; out_valid 4 cycles after accept.
// - c=(-2.0,0), max=50 -> |z|^2 stays at 4.0 exactly; depth=50 (no escape on equality).
// - c=(0,0), max=0 -> depth=0 after 1 cycle. c=(0,0), max=1023 -> depth=1023 after 1024 cycles.
// - Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> depth stable, in_ready=0, no new accept. After out_ready=1, IDLE, then the next accept.
// - Reset pulse at ITER cycle 10 of c=(0,0), max=100 -> out_valid never rises; in_ready=1 the cycle after reset falls.
// - With CARDIOID_CHECK_EN: c=(0,0), max=1000 -> depth=1000, out_valid 2 cycles after accept. c=(3.0,0) -> depth=1, 4 cycles after accept.

Source files
------------

// File: rtl/mandel_depth_engine.sv
// Iterative fixed-point Mandelbrot escape-depth engine: one z <= z^2 + c step per clock, from z = 0.
// Optional macro CARDIOID_CHECK_EN adds a 2-cycle main-cardioid / period-2 bulb pre-check.
module mandel_depth_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 28,
    parameter int DEPTH_WIDTH = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  c_re,
    input  logic signed [DATA_WIDTH-1:0]  c_im,
    input  logic        [DEPTH_WIDTH-1:0] max_iterations,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic        [DEPTH_WIDTH-1:0] depth,
    output logic        [DEPTH_WIDTH-1:0] out_max_iterations
);
    localparam int ZW = DATA_WIDTH + 2;
    localparam int PW = 2 * ZW;
    localparam int MW = PW + 1;
    localparam logic signed [MW-1:0] ESC_LIMIT = MW'(1) <<< (2 * FRAC_BITS + 2);

    typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

    state_t                       state_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic [DEPTH_WIDTH-1:0]       depth_q;
    logic [DEPTH_WIDTH-1:0]       out_max_q;
    logic [DEPTH_WIDTH-1:0]       max_q;
    logic [DEPTH_WIDTH-1:0]       n_q;
    logic signed [DATA_WIDTH-1:0] c_re_q;
    logic signed [DATA_WIDTH-1:0] c_im_q;
    logic signed [ZW-1:0]         z_re_q;
    logic signed [ZW-1:0]         z_im_q;
    logic signed [ZW-1:0]         z_re_d;
    logic signed [ZW-1:0]         z_im_d;
    logic signed [PW-1:0]         zr_sq;
    logic signed [PW-1:0]         zi_sq;
    logic signed [PW-1:0]         zr_zi;
    logic signed [MW-1:0]         mag_sq;
    logic                         escape;
    logic                         at_limit;

    // Arithmetic shift truncates toward -inf, back to the z format.
    function automatic logic signed [ZW-1:0] fx_trunc(input logic signed [PW-1:0] p, input int sh);
        return ZW'(p >>> sh);
    endfunction

    always_comb begin
        zr_sq    = PW'(z_re_q) * PW'(z_re_q);
        zi_sq    = PW'(z_im_q) * PW'(z_im_q);
        zr_zi    = PW'(z_re_q) * PW'(z_im_q);
        mag_sq   = MW'(zr_sq) + MW'(zi_sq);
        escape   = mag_sq > ESC_LIMIT;
        at_limit = n_q == max_q;
        z_re_d   = fx_trunc(zr_sq, FRAC_BITS) - fx_trunc(zi_sq, FRAC_BITS) + ZW'(c_re_q);
        // Shifting by one bit less folds in the factor of two of 2*zr*zi.
        z_im_d   = fx_trunc(zr_zi, FRAC_BITS - 1) + ZW'(c_im_q);
    end

`ifdef CARDIOID_CHECK_EN
    localparam int XW = DATA_WIDTH + 1;
    localparam int SW = 2 * XW;
    localparam int BW = SW + 1;
    localparam int QW = DATA_WIDTH + 4;
    localparam int CW = 2 * QW;
    localparam logic signed [XW-1:0] QUARTER = XW'(1) <<< (FRAC_BITS - 2);
    localparam logic signed [XW-1:0] ONE     = XW'(1) <<< FRAC_BITS;
    localparam logic signed [BW-1:0] BULB_R2 = BW'(1) <<< (2 * FRAC_BITS - 4);

    logic signed [XW-1:0] x_p0;
    logic signed [XW-1:0] cr1_p0;
    logic signed [SW-1:0] x_sq_p0;
    logic signed [SW-1:0] ci_sq_p0;
    logic signed [SW-1:0] cr1_sq_p0;
    logic                 bulb_p0;
    logic signed [XW-1:0] x_p1_q;
    logic signed [SW-1:0] x_sq_p1_q;
    logic signed [SW-1:0] ci_sq_p1_q;
    logic                 bulb_p1_q;
    logic                 vld_p1_q;
    logic signed [QW-1:0] q_p2;
    logic signed [QW-1:0] qx_p2;
    logic signed [CW-1:0] card_lhs_p2;
    logic signed [CW-1:0] card_rhs_p2;
    logic                 inside_p2;

    function automatic logic signed [QW-1:0] fx_trunc_q(input logic signed [SW-1:0] p);
        return QW'(p >>> FRAC_BITS);
    endfunction

    // Stage p0: squares of the shifted point and the period-2 bulb test.
    always_comb begin
        x_p0      = XW'(c_re_q) - QUARTER;
        cr1_p0    = XW'(c_re_q) + ONE;
        x_sq_p0   = SW'(x_p0) * SW'(x_p0);
        ci_sq_p0  = SW'(c_im_q) * SW'(c_im_q);
        cr1_sq_p0 = SW'(cr1_p0) * SW'(cr1_p0);
        bulb_p0   = (BW'(cr1_sq_p0) + BW'(ci_sq_p0)) <= BULB_R2;
    end

    always_ff @(posedge clk) begin
        x_p1_q     <= x_p0;
        x_sq_p1_q  <= x_sq_p0;
        ci_sq_p1_q <= ci_sq_p0;
        bulb_p1_q  <= bulb_p0;
    end

    // Stage p2: main cardioid test q*(q + x) <= c_im^2/4, compared at product scale.
    always_comb begin
        q_p2        = fx_trunc_q(x_sq_p1_q) + fx_trunc_q(ci_sq_p1_q);
        qx_p2       = q_p2 + QW'(x_p1_q);
        card_lhs_p2 = CW'(q_p2) * CW'(qx_p2);
        card_rhs_p2 = CW'(ci_sq_p1_q >>> 2);
        inside_p2   = (card_lhs_p2 <= card_rhs_p2) || bulb_p1_q;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            depth_q     <= '0;
            out_max_q   <= '0;
            max_q       <= '0;
            n_q         <= '0;
            c_re_q      <= '0;
            c_im_q      <= '0;
            z_re_q      <= '0;
            z_im_q      <= '0;
`ifdef CARDIOID_CHECK_EN
            vld_p1_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        c_re_q     <= c_re;
                        c_im_q     <= c_im;
                        max_q      <= max_iterations;
                        z_re_q     <= '0;
                        z_im_q     <= '0;
                        n_q        <= '0;
`ifdef CARDIOID_CHECK_EN
                        vld_p1_q   <= 1'b0;
                        state_q    <= CHECK;
`else
                        state_q    <= ITER;
`endif
                    end
                end
`ifdef CARDIOID_CHECK_EN
                CHECK: begin
                    if (!vld_p1_q) begin
                        vld_p1_q <= 1'b1;
                    end else begin
                        vld_p1_q <= 1'b0;
                        if (inside_p2) begin
                            depth_q     <= max_q;
                            out_max_q   <= max_q;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q     <= ITER;
                        end
                    end
                end
`endif
                ITER: begin
                    if (escape) begin
                        depth_q     <= n_q;
                        out_max_q   <= max_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (at_limit) begin
                        depth_q     <= max_q;
                        out_max_q   <= max_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        z_re_q <= z_re_d;
                        z_im_q <= z_im_d;
                        n_q    <= n_q + DEPTH_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready           = in_ready_q;
    assign out_valid          = out_valid_q;
    assign depth              = depth_q;
    assign out_max_iterations = out_max_q;

endmodule

// File: tb/tb_mandel_depth_engine.sv
// Directed-vector bench for mandel_depth_engine; expectations adapt to CARDIOID_CHECK_EN.
module tb_mandel_depth_engine;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] c_re = '0;
    logic signed [31:0] c_im = '0;
    logic        [9:0]  max_iterations = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [9:0]  depth;
    logic        [9:0]  out_max_iterations;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic signed [31:0] FX_ZERO  = 32'sh0000_0000;
    localparam logic signed [31:0] FX_ONE   = 32'sh1000_0000;
    localparam logic signed [31:0] FX_THREE = 32'sh3000_0000;
    localparam logic signed [31:0] FX_MTWO  = -32'sh2000_0000;

`ifdef CARDIOID_CHECK_EN
    localparam int CHK  = 2;
    localparam bit CARD = 1'b1;
`else
    localparam int CHK  = 0;
    localparam bit CARD = 1'b0;
`endif

    mandel_depth_engine #(
        .DATA_WIDTH(32),
        .FRAC_BITS(28),
        .DEPTH_WIDTH(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .c_re(c_re),
        .c_im(c_im),
        .max_iterations(max_iterations),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .depth(depth),
        .out_max_iterations(out_max_iterations)
    );

    always #5 clk = ~clk;

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_accept(input logic signed [31:0] cr, input logic signed [31:0] ci, input logic [9:0] mx);
        c_re           = cr;
        c_im           = ci;
        max_iterations = mx;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
        end
        n_checks++;
        if (depth !== 10'd0 || out_max_iterations !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_data: depth=%0d out_max=%0d, required 0 0", depth, out_max_iterations);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_escape_fast();
        bit ok;
        int lat;
        wait_ready(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL escape_fast_ready: in_ready=%b, required 1", in_ready);
        end
        do_accept(FX_THREE, FX_ZERO, 10'd100);
        wait_out(40, lat);
        n_checks++;
        if (lat !== 2 + CHK) begin
            n_fail++;
            $display("FAIL escape_fast_latency: got %0d cycles, required %0d", lat, 2 + CHK);
        end
        n_checks++;
        if (depth !== 10'd1) begin
            n_fail++;
            $display("FAIL escape_fast_depth: got %0d, required 1", depth);
        end
        n_checks++;
        if (out_max_iterations !== 10'd100) begin
            n_fail++;
            $display("FAIL escape_fast_max: got %0d, required 100", out_max_iterations);
        end
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL escape_fast_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_escape_three();
        bit ok;
        int lat;
        wait_ready(ok);
        do_accept(FX_ONE, FX_ZERO, 10'd100);
        wait_out(40, lat);
        n_checks++;
        if (ok !== 1'b1 || lat !== 4 + CHK) begin
            n_fail++;
            $display("FAIL escape_three_latency: got %0d cycles (ready=%b), required %0d", lat, ok, 4 + CHK);
        end
        n_checks++;
        if (depth !== 10'd3) begin
            n_fail++;
            $display("FAIL escape_three_depth: got %0d, required 3", depth);
        end
        release_out();
    endtask

    task automatic test_boundary_equal();
        bit ok;
        int lat;
        wait_ready(ok);
        do_accept(FX_MTWO, FX_ZERO, 10'd50);
        wait_out(200, lat);
        n_checks++;
        if (ok !== 1'b1 || lat !== 51 + CHK) begin
            n_fail++;
            $display("FAIL boundary_equal_latency: got %0d cycles, required %0d", lat, 51 + CHK);
        end
        n_checks++;
        if (depth !== 10'd50 || out_max_iterations !== 10'd50) begin
            n_fail++;
            $display("FAIL boundary_equal_depth: depth=%0d max=%0d, required 50 50", depth, out_max_iterations);
        end
        release_out();
    endtask

    task automatic test_max_limits();
        bit ok;
        int lat;
        wait_ready(ok);
        do_accept(FX_ZERO, FX_ZERO, 10'd0);
        wait_out(40, lat);
        n_checks++;
        if (ok !== 1'b1 || lat !== (CARD ? 2 : 1)) begin
            n_fail++;
            $display("FAIL max_zero_latency: got %0d cycles, required %0d", lat, CARD ? 2 : 1);
        end
        n_checks++;
        if (depth !== 10'd0) begin
            n_fail++;
            $display("FAIL max_zero_depth: got %0d, required 0", depth);
        end
        release_out();
        wait_ready(ok);
        do_accept(FX_ZERO, FX_ZERO, 10'd1023);
        wait_out(1100, lat);
        n_checks++;
        if (ok !== 1'b1 || lat !== (CARD ? 2 : 1024)) begin
            n_fail++;
            $display("FAIL max_full_latency: got %0d cycles, required %0d", lat, CARD ? 2 : 1024);
        end
        n_checks++;
        if (depth !== 10'd1023 || out_max_iterations !== 10'd1023) begin
            n_fail++;
            $display("FAIL max_full_depth: depth=%0d max=%0d, required 1023 1023", depth, out_max_iterations);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        wait_ready(ok);
        do_accept(FX_THREE, FX_ZERO, 10'd7);
        wait_out(40, lat);
        n_checks++;
        if (ok !== 1'b1 || lat !== 2 + CHK) begin
            n_fail++;
            $display("FAIL backpressure_first_latency: got %0d cycles, required %0d", lat, 2 + CHK);
        end
        c_re           = FX_ONE;
        c_im           = FX_ZERO;
        max_iterations = 10'd100;
        in_valid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (depth !== 10'd1 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_max_iterations !== 10'd7) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: depth=%0d max=%0d in_ready=%b out_valid=%b, required 1 7 0 1",
                         i, depth, out_max_iterations, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_no_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        c_re           = FX_ZERO;
        max_iterations = 10'd2;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL next_accept: in_ready=%b, required 0", in_ready);
        end
        wait_out(40, lat);
        n_checks++;
        if (lat !== 4 + CHK || depth !== 10'd3 || out_max_iterations !== 10'd100) begin
            n_fail++;
            $display("FAIL captured_point: lat=%0d depth=%0d max=%0d, required %0d 3 100",
                     lat, depth, out_max_iterations, 4 + CHK);
        end
        release_out();
    endtask

    task automatic test_ready_early();
        bit ok;
        int lat;
        wait_ready(ok);
        out_ready = 1'b1;
        do_accept(FX_ONE, FX_ZERO, 10'd100);
        wait_out(40, lat);
        n_checks++;
        if (ok !== 1'b1 || lat !== 4 + CHK || depth !== 10'd3) begin
            n_fail++;
            $display("FAIL ready_early_result: lat=%0d depth=%0d, required %0d 3", lat, depth, 4 + CHK);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_early_consume: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        wait_ready(ok);
`ifdef CARDIOID_CHECK_EN
        do_accept(FX_MTWO, FX_ZERO, 10'd100);
`else
        do_accept(FX_ZERO, FX_ZERO, 10'd100);
`endif
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || depth !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: in_ready=%b depth=%0d, required 1 0", in_ready, depth);
        end
        wait_out(120, lat);
        n_checks++;
        if (lat !== -1) begin
            n_fail++;
            $display("FAIL reset_mid_no_output: out_valid rose after %0d cycles, required never", lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_escape_fast();
        test_escape_three();
        test_boundary_equal();
        test_max_limits();
        test_back_to_back();
        test_ready_early();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
